// File: rtl/mem_stage_wait.sv
// Memory stage with a fixed-latency word-addressed data memory and the MEM/WB register.
// Optional macro MEM_FWD_EN adds combinational forwarding outputs (Fwd_WB_EN, Fwd_Dest, Fwd_Value).
module mem_stage_wait #(
    parameter int unsigned ADDRESS_LEN = 32,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESS_LEN-1:0] pc_in,
    input  logic [ADDRESS_LEN-1:0] ALU_Res,
    input  logic [ADDRESS_LEN-1:0] Val_Rm,
    input  logic                   MEM_W_EN,
    input  logic                   MEM_R_EN,
    input  logic                   WB_EN,
    input  logic [3:0]             Dest,
    output logic                   ready,
    output logic [ADDRESS_LEN-1:0] pc_out,
    output logic                   WB_EN_out,
    output logic                   MEM_R_EN_out,
    output logic [ADDRESS_LEN-1:0] ALU_Res_out,
    output logic [ADDRESS_LEN-1:0] Mem_Data_out,
    output logic [3:0]             Dest_out
`ifdef MEM_FWD_EN
    ,
    output logic                   Fwd_WB_EN,
    output logic [3:0]             Fwd_Dest,
    output logic [ADDRESS_LEN-1:0] Fwd_Value
`endif
);

    // state | meaning
    // IDLE  | no access in flight; a request here starts one (ready low)
    // WAIT  | counting latency cycles, cnt_q = 0 .. WAIT_CYCLES-1 (ready low)
    // DONE  | access completes on the edge leaving this state (ready high)
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [ADDRESS_LEN-1:0] BASE  = ADDRESS_LEN'(BASE_ADDR);
    localparam logic [ADDRESS_LEN-1:0] DEPTH = ADDRESS_LEN'(MEM_DEPTH);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDRESS_LEN-1:0] pc_q;
    logic                   wb_en_q;
    logic                   mem_r_en_q;
    logic [ADDRESS_LEN-1:0] alu_res_q;
    logic [ADDRESS_LEN-1:0] mem_data_q;
    logic [3:0]             dest_q;

    logic                   req;
    logic [ADDRESS_LEN-1:0] off;
    logic [ADDRESS_LEN-3:0] word_off;
    logic                   in_range;
    logic [IDX_W-1:0]       idx;
    logic [ADDRESS_LEN-1:0] rd_data;
    logic                   unused_byte_off;

    logic [ADDRESS_LEN-1:0] mem [MEM_DEPTH];

    assign req   = MEM_R_EN | MEM_W_EN;
    assign ready = !(req && (state_q != DONE));

    // Addresses below BASE borrow and are rejected before the depth compare.
    assign off             = ALU_Res - BASE;
    assign word_off        = off[ADDRESS_LEN-1:2];
    assign in_range        = (ALU_Res >= BASE) && ({2'b00, word_off} < DEPTH);
    assign idx             = word_off[IDX_W-1:0];
    assign unused_byte_off = ^off[1:0];
    assign rd_data         = in_range ? mem[idx] : '0;

    // Contents survive reset; a reset on the completing edge cancels the store.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == DONE) && MEM_W_EN && in_range) begin
            mem[idx] <= Val_Rm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pc_q       <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            dest_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        cnt_q   <= '0;
                        state_q <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // A stalled cycle inserts a bubble so the instruction retires once.
            if (ready) begin
                pc_q       <= pc_in;
                wb_en_q    <= WB_EN;
                mem_r_en_q <= MEM_R_EN;
                alu_res_q  <= ALU_Res;
                mem_data_q <= rd_data;
                dest_q     <= Dest;
            end else begin
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
            end
        end
    end

    assign pc_out       = pc_q;
    assign WB_EN_out    = wb_en_q;
    assign MEM_R_EN_out = mem_r_en_q;
    assign ALU_Res_out  = alu_res_q;
    assign Mem_Data_out = mem_data_q;
    assign Dest_out     = dest_q;

`ifdef MEM_FWD_EN
    assign Fwd_WB_EN = WB_EN & ~MEM_R_EN;
    assign Fwd_Dest  = Dest;
    assign Fwd_Value = ALU_Res;
`endif

endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench for mem_stage_wait: default-latency instance plus a zero-wait instance.
// Forwarding outputs are checked only when MEM_FWD_EN is defined.
module tb_mem_stage_wait;

    logic        clk;
    logic        rst;

    logic [31:0] pc_in, ALU_Res, Val_Rm;
    logic        MEM_W_EN, MEM_R_EN, WB_EN;
    logic [3:0]  Dest;
    logic        ready;
    logic [31:0] pc_out, ALU_Res_out, Mem_Data_out;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [3:0]  Dest_out;

    logic [31:0] pc_in0, ALU_Res0, Val_Rm0;
    logic        MEM_W_EN0, MEM_R_EN0, WB_EN0;
    logic [3:0]  Dest0;
    logic        ready0;
    logic [31:0] pc_out0, ALU_Res_out0, Mem_Data_out0;
    logic        WB_EN_out0, MEM_R_EN_out0;
    logic [3:0]  Dest_out0;

`ifdef MEM_FWD_EN
    logic        Fwd_WB_EN, Fwd_WB_EN0;
    logic [3:0]  Fwd_Dest, Fwd_Dest0;
    logic [31:0] Fwd_Value, Fwd_Value0;
`endif

    int n_err = 0;
    int n_chk = 0;

    mem_stage_wait u_dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .ALU_Res(ALU_Res), .Val_Rm(Val_Rm),
        .MEM_W_EN(MEM_W_EN), .MEM_R_EN(MEM_R_EN), .WB_EN(WB_EN), .Dest(Dest),
        .ready(ready), .pc_out(pc_out), .WB_EN_out(WB_EN_out),
        .MEM_R_EN_out(MEM_R_EN_out), .ALU_Res_out(ALU_Res_out),
        .Mem_Data_out(Mem_Data_out), .Dest_out(Dest_out)
`ifdef MEM_FWD_EN
        , .Fwd_WB_EN(Fwd_WB_EN), .Fwd_Dest(Fwd_Dest), .Fwd_Value(Fwd_Value)
`endif
    );

    mem_stage_wait #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .pc_in(pc_in0), .ALU_Res(ALU_Res0), .Val_Rm(Val_Rm0),
        .MEM_W_EN(MEM_W_EN0), .MEM_R_EN(MEM_R_EN0), .WB_EN(WB_EN0), .Dest(Dest0),
        .ready(ready0), .pc_out(pc_out0), .WB_EN_out(WB_EN_out0),
        .MEM_R_EN_out(MEM_R_EN_out0), .ALU_Res_out(ALU_Res_out0),
        .Mem_Data_out(Mem_Data_out0), .Dest_out(Dest_out0)
`ifdef MEM_FWD_EN
        , .Fwd_WB_EN(Fwd_WB_EN0), .Fwd_Dest(Fwd_Dest0), .Fwd_Value(Fwd_Value0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pc_in = '0; ALU_Res = '0; Val_Rm = '0;
        MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; WB_EN = 1'b0; Dest = '0;
    endtask

    task automatic idle_in0();
        pc_in0 = '0; ALU_Res0 = '0; Val_Rm0 = '0;
        MEM_W_EN0 = 1'b0; MEM_R_EN0 = 1'b0; WB_EN0 = 1'b0; Dest0 = '0;
    endtask

    // Drives one memory instruction through the default instance: 4 stalled cycles,
    // 1 ready cycle, then the inputs go idle right after the capture edge.
    task automatic mem_access(input logic w, input logic r, input logic wb,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] dst, input logic [31:0] pc);
        pc_in = pc; ALU_Res = addr; Val_Rm = data;
        MEM_W_EN = w; MEM_R_EN = r; WB_EN = wb; Dest = dst;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("stall_ready", 32'(ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bubble_wb", 32'(WB_EN_out), 32'd0);
            chk("bubble_mr", 32'(MEM_R_EN_out), 32'd0);
        end
        #2;
        chk("done_ready", 32'(ready), 32'd1);
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        idle_in0();
        rst = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_wb", 32'(WB_EN_out), 32'd0);
        chk("rst_mr", 32'(MEM_R_EN_out), 32'd0);
        chk("rst_alu", ALU_Res_out, 32'd0);
        chk("rst_data", Mem_Data_out, 32'd0);
        chk("rst_dest", 32'(Dest_out), 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd1);
        rst = 1'b0;

        // ALU instruction: no stall, one-cycle latency
        pc_in = 32'h100; ALU_Res = 32'd7; WB_EN = 1'b1; Dest = 4'd5;
        #2;
        chk("alu_ready", 32'(ready), 32'd1);
`ifdef MEM_FWD_EN
        chk("alu_fwd_wb", 32'(Fwd_WB_EN), 32'd1);
        chk("alu_fwd_dest", 32'(Fwd_Dest), 32'd5);
        chk("alu_fwd_val", Fwd_Value, 32'd7);
`endif
        step();
        chk("alu_res", ALU_Res_out, 32'd7);
        chk("alu_dest", 32'(Dest_out), 32'd5);
        chk("alu_wb", 32'(WB_EN_out), 32'd1);
        chk("alu_mr", 32'(MEM_R_EN_out), 32'd0);
        chk("alu_pc", pc_out, 32'h100);
        idle_in();

        // STR then LDR at 1028
        mem_access(1'b1, 1'b0, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0, 32'h104);
        chk("str_wb", 32'(WB_EN_out), 32'd0);
        chk("str_mr", 32'(MEM_R_EN_out), 32'd0);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1028, 32'd0, 4'd3, 32'h108);
        chk("ldr_data", Mem_Data_out, 32'hDEADBEEF);
        chk("ldr_mr", 32'(MEM_R_EN_out), 32'd1);
        chk("ldr_dest", 32'(Dest_out), 32'd3);
        chk("ldr_wb", 32'(WB_EN_out), 32'd1);
        chk("ldr_pc", pc_out, 32'h108);
        chk("ldr_alu", ALU_Res_out, 32'd1028);
        step();
        chk("ldr_wb_once", 32'(WB_EN_out), 32'd0);

        // Read+write together returns pre-write data
        mem_access(1'b1, 1'b1, 1'b1, 32'd1028, 32'h12345678, 4'd4, 32'h10C);
        chk("rw_data", Mem_Data_out, 32'hDEADBEEF);
        chk("rw_mr", 32'(MEM_R_EN_out), 32'd1);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1030, 32'd0, 4'd4, 32'h110);
        chk("rw_after", Mem_Data_out, 32'h12345678);

        // Boundaries: last word, below base, one past end
        mem_access(1'b1, 1'b0, 1'b0, 32'd1276, 32'h0000A5A5, 4'd0, 32'h114);
        mem_access(1'b1, 1'b0, 1'b0, 32'd1024, 32'h0BADF00D, 4'd0, 32'h118);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1276, 32'd0, 4'd6, 32'h11C);
        chk("last_word", Mem_Data_out, 32'h0000A5A5);
        mem_access(1'b1, 1'b0, 1'b0, 32'd1020, 32'h00000055, 4'd0, 32'h120);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1020, 32'd0, 4'd6, 32'h124);
        chk("below_base", Mem_Data_out, 32'd0);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1276, 32'd0, 4'd6, 32'h128);
        chk("below_no_alias", Mem_Data_out, 32'h0000A5A5);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1280, 32'd0, 4'd6, 32'h12C);
        chk("past_end", Mem_Data_out, 32'd0);
        mem_access(1'b0, 1'b1, 1'b1, 32'd1024, 32'd0, 4'd6, 32'h130);
        chk("word0", Mem_Data_out, 32'h0BADF00D);

        // Reset while in WAIT (cnt=1) aborts the store
        mem_access(1'b1, 1'b0, 1'b0, 32'd1032, 32'h11111111, 4'd0, 32'h134);
        pc_in = 32'h138; ALU_Res = 32'd1032; Val_Rm = 32'h22222222; MEM_W_EN = 1'b1;
        step();
        step();
        #2;
        chk("abort_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        step();
        chk("abort_pc", pc_out, 32'd0);
        chk("abort_alu", ALU_Res_out, 32'd0);
        chk("abort_wb", 32'(WB_EN_out), 32'd0);
        idle_in();
        #2;
        chk("abort_idle_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        step();
        mem_access(1'b0, 1'b1, 1'b1, 32'd1032, 32'd0, 4'd7, 32'h13C);
        chk("abort_old_data", Mem_Data_out, 32'h11111111);

        // Zero-wait instance: one stalled cycle per access
        pc_in0 = 32'h200; ALU_Res0 = 32'd1024; Val_Rm0 = 32'h00000077; MEM_W_EN0 = 1'b1;
        #2;
        chk("w0_str_stall", 32'(ready0), 32'd0);
        step();
        #2;
        chk("w0_str_done", 32'(ready0), 32'd1);
        step();
        idle_in0();
        pc_in0 = 32'h204; ALU_Res0 = 32'd1024; MEM_R_EN0 = 1'b1; WB_EN0 = 1'b1; Dest0 = 4'd9;
        #2;
        chk("w0_ldr_stall", 32'(ready0), 32'd0);
`ifdef MEM_FWD_EN
        chk("w0_fwd_wb", 32'(Fwd_WB_EN0), 32'd0);
`endif
        step();
        chk("w0_bubble_wb", 32'(WB_EN_out0), 32'd0);
        #2;
        chk("w0_ldr_done", 32'(ready0), 32'd1);
        step();
        idle_in0();
        chk("w0_ldr_data", Mem_Data_out0, 32'h00000077);
        chk("w0_ldr_mr", 32'(MEM_R_EN_out0), 32'd1);
        chk("w0_ldr_wb", 32'(WB_EN_out0), 32'd1);
        chk("w0_ldr_dest", 32'(Dest_out0), 32'd9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
